alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  - ID/EX + EX/MEM pipeline slice that drives the ALU and consumes its result.
//  - Decodes ALUOp/funct into the 3-bit aluControl code and registers the operands.
//  - Presents both to the combinational ALU, then captures aluResult/zero into an output register.
//  - Sits between decode and memory stage; valid/ready handshake on both sides, plus flush.
// PARAMETERS
//  WIDTH  32  datapath width (operands, immediate, result)
//  CNT_W  8   width of the saturating illegal-op counter
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  in_valid       in   1      decode offers an instruction
//  in_ready       out  1      stage 1 accepts this cycle
//  alu_op         in   2      00 add(lw/sw), 01 sub(beq), 10 R-type (use funct), 11 illegal
//  funct          in   6      R-type function field
//  rs_data        in   WIDTH  operand A
//  rt_data        in   WIDTH  operand B (register)
//  imm            in   WIDTH  sign-extended immediate
//  alu_src        in   1      1: operand B = imm, 0: rt_data
//  is_branch      in   1      instruction is beq
//  flush          in   1      kill all in-flight instructions
//  alu_in1        out  WIDTH  to ALU in1 (stage-1 register)
//  alu_in2        out  WIDTH  to ALU in2 (stage-1 register, mux already applied)
//  alu_control    out  3      to ALU aluControl (stage-1 register)
//  alu_result     in   WIDTH  from ALU aluResult
//  alu_zero       in   1      from ALU zero
//  out_valid      out  1      stage 2 holds a result
//  out_ready      in   1      memory stage accepts
//  out_result     out  WIDTH  registered ALU result
//  branch_taken   out  1      registered is_branch & alu_zero
//  illegal_op     out  1      registered: instruction in stage 2 was illegal
//  illegal_count  out  CNT_W  saturating count of illegal ops leaving stage 2
// BEHAVIOUR
//  - Decode: alu_op 00->010, 01->110; 10 with funct 100000->010, 100010->110, 100100->000,
//    100101->001, 101010->111. Any other alu_op/funct: code 010, illegal bit set.
//  - Only these five codes are ever driven on alu_control.
//  - Reset: s1_valid=s2_valid=0; alu_in1/alu_in2/out_result=0; alu_control=3'b010;
//    branch_taken=illegal_op=0; illegal_count=0.
//  - s2_adv = !s2_valid | out_ready.
//  - s1_adv = s1_valid & s2_adv.
//  - in_ready = !flush & (!s1_valid | s2_adv).
//  - Accept when in_valid & in_ready. Stage-1 registers load; s1_valid<=1.
//  - If s1 advances with no new accept: s1_valid<=0 and data holds.
//  - s1_adv: stage 2 loads alu_result, is_branch&alu_zero, illegal; s2_valid<=1.
//  - out_valid & out_ready with no s1_adv: s2_valid<=0.
//  - Latency: accept at edge N -> ALU inputs valid after N -> out_valid after edge N+1.
//    Back-to-back throughput is 1/cycle when out_ready is held high.
//  - Stall: out_ready=0 with s2 full holds every register. ALU inputs stay stable.
//  - Flush: s1_valid<=0 and s2_valid<=0 at the edge; flush wins over accept and advance.
//    Data registers may hold stale values. A flushed op never increments illegal_count.
//  - illegal_count increments when out_valid & out_ready & illegal_op. Saturates at 2^CNT_W-1.
//  - Reset mid-operation: all in-flight ops dropped, counter cleared.
// STRUCTURE
//  - Shared package alu_pkg: ALUOp constants, funct constants, ALU control codes
//    (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111).
//  - Sub-module alu_ctrl_decode: combinational alu_op/funct -> {code[2:0], illegal}.
//  - Top holds both pipeline registers, the handshake and the counter.
//  - Bench instantiates the existing ALU between alu_in*/alu_control and alu_result/alu_zero.
// TESTING
//  - R-type stream: add 5+3, sub 5-3, and 12&10, or 12|10, slt 2<7 with out_ready=1
//    -> out_result 8,2,8,14,1 on consecutive cycles; first appears 2 cycles after accept.
//  - beq: rs=rt=9, alu_op=01, is_branch=1 -> branch_taken=1.
//    Repeat with rt=4 -> branch_taken=0, out_result=5.
//  - lw with alu_src=1: rs=100, imm=-4 -> out_result=96. alu_src=0 with rt=7 -> 107.
//  - Backpressure: out_ready=0 for 3 cycles with a stream offered -> in_ready drops after 2 accepts.
//    Outputs are held stable; no op is lost or duplicated after release.
//  - Flush with both stages full and in_valid=1 -> next cycle out_valid=0, s1 empty.
//    The flushed op is not accepted.
//  - Illegal funct 000000 x3 plus alu_op=11 -> illegal_op=1 and alu_control=010 each time;
//    illegal_count=4. 300 illegal ops -> count saturates at 255.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALUOp / funct encodings and ALU control codes for the
//                ALU issue stage and its control decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // ALUOp field driven by the main decoder
    localparam logic [1:0] c_aluop_mem   = 2'b00;  // lw/sw address add
    localparam logic [1:0] c_aluop_beq   = 2'b01;  // branch compare subtract
    localparam logic [1:0] c_aluop_rtype = 2'b10;  // use funct field

    // R-type funct encodings understood by the ALU
    localparam logic [5:0] c_funct_add = 6'b100000;
    localparam logic [5:0] c_funct_sub = 6'b100010;
    localparam logic [5:0] c_funct_and = 6'b100100;
    localparam logic [5:0] c_funct_or  = 6'b100101;
    localparam logic [5:0] c_funct_slt = 6'b101010;

    // ALU control codes presented on aluControl
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Decoder result: control code plus an illegal-instruction marker
    typedef struct packed {
        logic [2:0] code;
        logic       illegal;
    } alu_dec_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Combinational ALUOp/funct to ALU control decoder. Unknown
//                encodings fall back to ADD and raise the illegal flag so the
//                ALU never sees a code outside the supported five.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_dec_t   dec
);

    // Map ALUOp and funct onto a control code; default is a safe ADD
    always_comb begin
        dec.code    = ALU_ADD;
        dec.illegal = 1'b0;
        case (alu_op)
            c_aluop_mem: dec.code = ALU_ADD;
            c_aluop_beq: dec.code = ALU_SUB;
            c_aluop_rtype: begin
                case (funct)
                    c_funct_add: dec.code = ALU_ADD;
                    c_funct_sub: dec.code = ALU_SUB;
                    c_funct_and: dec.code = ALU_AND;
                    c_funct_or:  dec.code = ALU_OR;
                    c_funct_slt: dec.code = ALU_SLT;
                    default:     dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Two-register pipeline slice around an external combinational
//                ALU. Stage 1 holds decoded control and operands that feed the
//                ALU; stage 2 captures the ALU result, branch outcome and the
//                illegal marker. Valid/ready on both sides, flush, and a
//                saturating count of illegal ops retired from stage 2.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic             is_branch,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             branch_taken,
    output logic             illegal_op,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Stage 1 (ALU input side)
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_alu_in1;
    logic [WIDTH-1:0] r_alu_in2;
    logic [2:0]       r_alu_control;
    logic             r_s1_branch;
    logic             r_s1_illegal;

    // Stage 2 (ALU result side)
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_branch_taken;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_illegal_count;

    alu_dec_t w_dec;
    logic     w_s2_adv;
    logic     w_s1_adv;
    logic     w_accept;
    logic     w_retire;

    alu_ctrl_decode u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .dec    (w_dec)
    );

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = r_s1_valid & w_s2_adv;
    assign in_ready = ~flush & (~r_s1_valid | w_s2_adv);
    assign w_accept = in_valid & in_ready;
    // A stage-2 op flushed on the same edge does not count as retired
    assign w_retire = r_s2_valid & out_ready & ~flush;

    // Stage 1: capture decoded op and muxed operands on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_alu_in1     <= '0;
            r_alu_in2     <= '0;
            r_alu_control <= ALU_ADD;
            r_s1_branch   <= 1'b0;
            r_s1_illegal  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid    <= 1'b1;
            r_alu_in1     <= rs_data;
            r_alu_in2     <= alu_src ? imm : rt_data;
            r_alu_control <= w_dec.code;
            r_s1_branch   <= is_branch;
            r_s1_illegal  <= w_dec.illegal;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: capture the ALU result when stage 1 moves forward
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid     <= 1'b0;
            r_out_result   <= '0;
            r_branch_taken <= 1'b0;
            r_illegal_op   <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid     <= 1'b1;
            r_out_result   <= alu_result;
            r_branch_taken <= r_s1_branch & alu_zero;
            r_illegal_op   <= r_s1_illegal;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Saturating count of illegal ops handed to the memory stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_count <= '0;
        end else if (w_retire && r_illegal_op && (r_illegal_count != c_cnt_max)) begin
            r_illegal_count <= r_illegal_count + 1'b1;
        end
    end

    assign alu_in1       = r_alu_in1;
    assign alu_in2       = r_alu_in2;
    assign alu_control   = r_alu_control;
    assign out_valid     = r_s2_valid;
    assign out_result    = r_out_result;
    assign branch_taken  = r_branch_taken;
    assign illegal_op    = r_illegal_op;
    assign illegal_count = r_illegal_count;

endmodule
`default_nettype wire
